// File: rtl/mont_mul_core_pkg.sv
// Shared RSA package: Montgomery multiplier state naming, also used by the
// exponent controller.
package mont_mul_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } mm_state_t;

endpackage

// File: rtl/mont_mul_core_if.sv
// Handshake and operand bus between the exponent controller (master) and the
// Montgomery multiplier core (slave).
interface mont_mul_core_if #(
  parameter int unsigned W = 2048
);
  logic         mul_rst;
  logic         mul_start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] n;
  logic [W-1:0] result;
  logic         mul_finish;

  modport master (
    output mul_rst, mul_start, x, y, n,
    input  result, mul_finish
  );

  modport slave (
    input  mul_rst, mul_start, x, y, n,
    output result, mul_finish
  );
endinterface

// File: rtl/mont_mul_core_add_shift.sv
// One radix-2 Montgomery step: (s + a*y + q*n) >> 1, with q chosen so the sum
// is even. Purely combinational.
module mont_add_shift #(
  parameter int unsigned W = 2048
) (
  input  logic [W+1:0] s,
  input  logic [W-1:0] y,
  input  logic [W-1:0] n,
  input  logic         a,
  output logic [W+1:0] s_next
);
  logic [W+1:0] s1;
  logic [W+1:0] s2;

  always_comb begin
    s1     = s + (a ? {2'b00, y} : '0);
    s2     = s1 + (s1[0] ? {2'b00, n} : '0);
    s_next = s2 >> 1;
  end
endmodule

// File: rtl/mont_mul_core.sv
// Bit-serial Montgomery multiplier: result = x*y*2^-W mod n after W+1 cycles.
// Responder to the exponent controller's mul_rst/mul_start/mul_finish handshake.
module mont_mul_core
  import mont_mul_core_pkg::*;
#(
  parameter int unsigned W = 2048
) (
  input logic             clk,
  input logic             mm_rst,
  mont_mul_core_if.slave  bus
);
  localparam int unsigned      CW   = $clog2(W) + 1;
  localparam logic [CW-1:0]    LAST = CW'(W - 1);

  mm_state_t    state;
  logic [W-1:0] x_reg;
  logic [W-1:0] y_reg;
  logic [W-1:0] n_reg;
  logic [W+1:0] s;
  logic [W+1:0] s_next;
  logic [W+1:0] n_ext;
  logic [W-1:0] final_val;
  logic [CW-1:0] cnt;
  logic          x_bit;

  assign x_bit = x_reg[cnt[CW-2:0]];
  assign n_ext = {2'b00, n_reg};

  mont_add_shift #(.W(W)) u_add_shift (
    .s      (s),
    .y      (y_reg),
    .n      (n_reg),
    .a      (x_bit),
    .s_next (s_next)
  );

  // Single conditional subtraction; S < 2n keeps one pass sufficient.
  always_comb begin
    final_val = s[W-1:0];
    if (s >= n_ext) final_val = W'(s - n_ext);
  end

  always_ff @(posedge clk or posedge mm_rst) begin
    if (mm_rst) begin
      state          <= IDLE;
      bus.mul_finish <= 1'b0;
      bus.result     <= '0;
      s              <= '0;
      cnt            <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      n_reg          <= '0;
    end else if (bus.mul_rst) begin
      // Initiator clear wins in every state; result keeps its last value.
      state          <= IDLE;
      bus.mul_finish <= 1'b0;
      s              <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.mul_finish <= 1'b0;
          if (bus.mul_start) begin
            x_reg <= bus.x;
            y_reg <= bus.y;
            n_reg <= bus.n;
            s     <= '0;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          s   <= s_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FINAL;
        end
        FINAL: begin
          bus.result     <= final_val;
          bus.mul_finish <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          bus.mul_finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mul_core.sv
// Self-checking bench for mont_mul_core at W=8 against an arithmetic
// Montgomery reference (search for r with r*2^W == x*y mod n).
module tb_mont_mul_core;
  localparam int unsigned W   = 8;
  localparam int          LAT = W + 1;

  logic clk    = 1'b0;
  logic mm_rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  mont_mul_core_if #(.W(W)) bus ();

  mont_mul_core #(.W(W)) dut (
    .clk    (clk),
    .mm_rst (mm_rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mont(input int unsigned xv, input int unsigned yv,
                                            input int unsigned nv);
    int unsigned t;
    t = (xv * yv) % nv;
    for (int unsigned r = 0; r < nv; r++)
      if (((r << W) % nv) == t) return r[W-1:0];
    return '0;
  endfunction

  task automatic rand_operands(output logic [W-1:0] xv, output logic [W-1:0] yv,
                               output logic [W-1:0] nv);
    nv = W'($urandom_range(127, 1) * 2 + 1);
    xv = W'($urandom_range(int'(nv) - 1, 0));
    yv = W'($urandom_range(int'(nv) - 1, 0));
  endtask

  // Optionally clears via mul_rst, starts one operation, waits (bounded) for mul_finish.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [W-1:0] nv,
                        input bit pre_clear, output logic [W-1:0] res, output int lat);
    if (pre_clear) begin
      @(posedge clk); #1;
      bus.mul_rst = 1'b1; bus.mul_start = 1'b0;
    end
    @(posedge clk); #1;
    bus.mul_rst = 1'b0;
    bus.x = xv; bus.y = yv; bus.n = nv;
    bus.mul_start = 1'b1;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    lat = 0;
    while (bus.mul_finish !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic test_reset;
    bus.mul_rst = 1'b0; bus.mul_start = 1'b0;
    bus.x = '0; bus.y = '0; bus.n = 8'd13;
    mm_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (bus.mul_finish !== 1'b0 || bus.result !== '0) begin
      mismatched++;
      $display("FAIL reset_state: finish=%b result=%0d, required finish=0 result=0",
               bus.mul_finish, bus.result);
    end
    mm_rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    compared++;
    if (bus.mul_finish !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_no_start: finish=%b, required 0", bus.mul_finish);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] tx[5] = '{8'd5, 8'd12, 8'd254, 8'd1, 8'd12};
    logic [W-1:0] ty[5] = '{8'd7, 8'd12, 8'd254, 8'd1, 8'd1};
    logic [W-1:0] tn[5] = '{8'd13, 8'd13, 8'd255, 8'd3, 8'd13};
    logic [W-1:0] res, exp_r;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(tx[i], ty[i], tn[i], (i != 0), res, lat);
      exp_r = ref_mont(tx[i], ty[i], tn[i]);
      compared++;
      if (res !== exp_r || lat != LAT) begin
        mismatched++;
        $display("FAIL directed_%0d: result=%0d latency=%0d, required result=%0d latency=%0d",
                 i, res, lat, exp_r, LAT);
      end
    end
  endtask

  task automatic test_zero_operand;
    logic [W-1:0] res;
    int lat;
    run_op(8'd0, 8'd9, 8'd13, 1'b1, res, lat);
    compared++;
    if (res !== '0 || lat != LAT) begin
      mismatched++;
      $display("FAIL zero_x: result=%0d latency=%0d, required 0 and %0d", res, lat, LAT);
    end
    run_op(8'd11, 8'd0, 8'd251, 1'b1, res, lat);
    compared++;
    if (res !== '0 || lat != LAT) begin
      mismatched++;
      $display("FAIL zero_y: result=%0d latency=%0d, required 0 and %0d", res, lat, LAT);
    end
  endtask

  task automatic test_mm_rst_abort;
    logic [W-1:0] res;
    int lat, rises;
    run_op(8'd12, 8'd12, 8'd13, 1'b1, res, lat);
    @(posedge clk); #1;
    bus.mul_rst = 1'b1;
    @(posedge clk); #1;
    bus.mul_rst = 1'b0;
    bus.x = 8'd5; bus.y = 8'd7; bus.n = 8'd13; bus.mul_start = 1'b1;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mm_rst = 1'b1;
    #1;
    compared++;
    if (bus.result !== '0 || bus.mul_finish !== 1'b0) begin
      mismatched++;
      $display("FAIL async_mm_rst: result=%0d finish=%b, required 0 and 0",
               bus.result, bus.mul_finish);
    end
    repeat (2) @(posedge clk);
    #1;
    mm_rst = 1'b0;
    rises = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.mul_finish === 1'b1) rises++;
    end
    compared++;
    if (rises != 0 || bus.result !== '0) begin
      mismatched++;
      $display("FAIL abort_no_finish: finish_cycles=%0d result=%0d, required 0 and 0",
               rises, bus.result);
    end
    run_op(8'd12, 8'd12, 8'd13, 1'b0, res, lat);
    compared++;
    if (res !== 8'd3 || lat != LAT) begin
      mismatched++;
      $display("FAIL restart_after_mm_rst: result=%0d latency=%0d, required 3 and %0d",
               res, lat, LAT);
    end
  endtask

  task automatic test_done_hold;
    logic [W-1:0] xv, yv, nv, res, exp_r;
    int lat, bad;
    rand_operands(xv, yv, nv);
    exp_r = ref_mont(xv, yv, nv);
    run_op(xv, yv, nv, 1'b1, res, lat);
    compared++;
    if (res !== exp_r || lat != LAT) begin
      mismatched++;
      $display("FAIL hold_op: result=%0d latency=%0d, required %0d and %0d",
               res, lat, exp_r, LAT);
    end
    bus.mul_start = 1'b1;
    bad = 0;
    repeat (20) begin
      bus.x = W'($urandom); bus.y = W'($urandom); bus.n = W'($urandom);
      @(posedge clk); #1;
      if (bus.mul_finish !== 1'b1 || bus.result !== exp_r) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL done_hold: unstable_cycles=%0d, required 0", bad);
    end
    bus.mul_rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (bus.mul_finish !== 1'b0 || bus.result !== exp_r) begin
      mismatched++;
      $display("FAIL mul_rst_clear: finish=%b result=%0d, required 0 and %0d",
               bus.mul_finish, bus.result, exp_r);
    end
    @(posedge clk); #1;
    bus.mul_rst = 1'b0; bus.mul_start = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.mul_finish !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL rst_beats_start: finish_cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_input_change;
    logic [W-1:0] xv, yv, nv, res, exp_r;
    int lat;
    for (int k = 0; k < 3; k++) begin
      rand_operands(xv, yv, nv);
      exp_r = ref_mont(xv, yv, nv);
      @(posedge clk); #1;
      bus.mul_rst = 1'b1;
      @(posedge clk); #1;
      bus.mul_rst = 1'b0;
      bus.x = xv; bus.y = yv; bus.n = nv; bus.mul_start = 1'b1;
      @(posedge clk); #1;
      bus.mul_start = 1'b0;
      lat = 0;
      while (bus.mul_finish !== 1'b1 && lat < 64) begin
        bus.x = W'($urandom); bus.y = W'($urandom); bus.n = W'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      res = bus.result;
      compared++;
      if (res !== exp_r || lat != LAT) begin
        mismatched++;
        $display("FAIL input_change_%0d: result=%0d latency=%0d, required %0d and %0d",
                 k, res, lat, exp_r, LAT);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] xv, yv, nv, res, exp_r;
    int lat;
    for (int k = 0; k < 40; k++) begin
      rand_operands(xv, yv, nv);
      exp_r = ref_mont(xv, yv, nv);
      run_op(xv, yv, nv, 1'b1, res, lat);
      compared++;
      if (res !== exp_r || lat != LAT) begin
        mismatched++;
        $display("FAIL random_%0d: x=%0d y=%0d n=%0d result=%0d latency=%0d, required %0d and %0d",
                 k, xv, yv, nv, res, lat, exp_r, LAT);
      end
    end
  endtask

  task automatic test_out_of_contract;
    logic [W-1:0] res;
    int lat;
    run_op(8'd200, 8'd250, 8'd10, 1'b1, res, lat);
    compared++;
    if (lat != LAT) begin
      mismatched++;
      $display("FAIL contract_even_n: latency=%0d, required %0d", lat, LAT);
    end
    run_op(8'd255, 8'd255, 8'd1, 1'b1, res, lat);
    compared++;
    if (lat != LAT) begin
      mismatched++;
      $display("FAIL contract_n1: latency=%0d, required %0d", lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_operand();
    test_mm_rst_abort();
    test_done_hold();
    test_input_change();
    test_random();
    test_out_of_contract();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mont_mul_core.md
MONT_MUL_CORE -- requirements
Module: mont_mul_core

Interface
REQ-001 Parameter W, default 2048; operand/modulus width in bits, W >= 4.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 mm_rst  in  1  reset, asynchronous, active-high.
REQ-004 mul_rst  in  1  synchronous clear from initiator; returns core to IDLE.
REQ-005 mul_start  in  1  level request; sampled only in IDLE.
REQ-006 x  in  W  multiplicand, unsigned, x < n.
REQ-007 y  in  W  multiplier, unsigned, y < n.
REQ-008 n  in  W  modulus, odd, n > 1.
REQ-009 result  out  W  registered x*y*2^-W mod n.
REQ-010 mul_finish  out  1  registered done flag.

Function
REQ-011 Core SHALL be the responder to the mul_rst/mul_start/mul_finish handshake of the Montgomery exponent controller.
REQ-012 States SHALL be IDLE, ITER, FINAL, DONE; encoding 2 bits.
REQ-013 IDLE: mul_finish=0; on mul_start=1 and mul_rst=0, latch x, y, n into internal registers, clear accumulator S (W+2 bits) and bit counter, go ITER.
REQ-014 ITER: per cycle, bit i = x_reg[i] (LSB first): S1 = S + (x_i ? y_reg : 0); S2 = S1 + (S1[0] ? n_reg : 0); S = S2 >> 1; counter increments.
REQ-015 ITER SHALL run exactly W cycles (counter 0..W-1, width clog2(W)+1), then go FINAL.
REQ-016 FINAL: result = (S >= n_reg) ? S - n_reg : S, truncated to W bits; mul_finish set to 1; go DONE; one cycle.
REQ-017 Latency: if mul_start is sampled at edge t0, mul_finish SHALL be high after edge t0+W+1.
REQ-018 DONE: mul_finish and result held stable; mul_start ignored (high or low); leave only via mul_rst.
REQ-019 mul_rst=1 in any state SHALL, at next edge, go IDLE, clear mul_finish, clear S and counter; result retains last value.
REQ-020 mul_rst and mul_start both high in IDLE: mul_rst wins, no operation starts.
REQ-021 Input changes on x, y, n after the latching edge SHALL not affect the running operation.
REQ-022 Accumulator SHALL never overflow: S < 2n holds throughout for x, y < n, so W+2 bits suffice.
REQ-023 x=0 or y=0 SHALL yield result 0 with the same latency; no early termination.
REQ-024 Operands outside the x,y < n / odd n contract: result undefined, but the FSM SHALL still reach DONE in W+1 cycles.

Reset
REQ-025 mm_rst SHALL asynchronously force: state IDLE, mul_finish 0, result 0, S 0, counter 0, operand registers 0.
REQ-026 mm_rst during ITER or FINAL SHALL abort the operation with no mul_finish pulse; a new mul_start after release starts cleanly.
REQ-027 After mm_rst release, first mul_start sampling edge SHALL behave as REQ-013.

Structure
REQ-028 State encoding constants (IDLE, ITER, FINAL, DONE) SHALL live in the shared RSA package, reused by the exponent controller for state naming.
REQ-029 A single sub-module, mont_add_shift (combinational S + a*y + q*n then >>1, W+2 bits), is natural; all registers stay in mont_mul_core.
REQ-030 No division or modulo operators; one W+2-bit comparator/subtractor in FINAL.

Verification (W=8)
REQ-031 n=13, x=5, y=7, mul_start pulse -> after 9 cycles mul_finish=1, result=1.
REQ-032 n=13, x=12, y=12 -> result=3; n=255, x=254, y=254 -> result=1 (exercises final subtraction path).
REQ-033 n=13, x=0, y=9 -> result=0, mul_finish exactly 9 cycles after start.
REQ-034 Start n=13, x=5, y=7; assert mm_rst at cycle 4 -> mul_finish never rises, result=0; restart with x=12, y=12 -> result=3.
REQ-035 Hold mul_start high through DONE for 20 cycles -> mul_finish stays 1, result stable; pulse mul_rst -> mul_finish=0 next edge; mul_rst and mul_start high together -> stays IDLE.
REQ-036 Change x, y, n every cycle during ITER -> result matches operands latched at start.
